// File: rtl/mdu_hilo_pkg.sv
// ---------------------------------------------------------------------------
// mips_defs : shared md_op encodings and default MDU latencies. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_defs;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;

  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_hilo_if.sv
// ---------------------------------------------------------------------------
// mdu_hilo_if : request/result bundle between EX stage and the MDU. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mdu_hilo_if;
  logic                          start;
  logic [mips_defs::MD_OP_W-1:0] md_op;
  logic [31:0]                   op1;
  logic [31:0]                   op2;
  logic                          busy;
  logic [31:0]                   hi;
  logic [31:0]                   lo;

  modport master (output start, md_op, op1, op2, input busy, hi, lo);
  modport slave  (input start, md_op, op1, op2, output busy, hi, lo);
endinterface

`default_nettype wire

// File: rtl/mdu_latency_ctr.sv
// ---------------------------------------------------------------------------
// mdu_latency_ctr : down-counter giving busy and a one-cycle commit pulse. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_latency_ctr (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        load,
  input  wire logic [31:0] load_val,
  output logic             busy,
  output logic             commit
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 32'd0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != 32'd0) begin
      r_cnt <= r_cnt - 32'd1;
    end
  end

  // Commit fires on the edge that takes the count from 1 to 0.
  assign busy   = (r_cnt != 32'd0);
  assign commit = (r_cnt == 32'd1);

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ---------------------------------------------------------------------------
// mdu_hilo : multiply/divide unit with architectural HI/LO registers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_hilo
  import mips_defs::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input wire logic  clk,
  input wire logic  reset,
  mdu_hilo_if.slave bus
);

  logic [MD_OP_W-1:0] r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic        w_busy;
  logic        w_commit;
  logic        w_accept;
  logic        w_load;
  logic [31:0] w_load_val;

  assign w_accept   = bus.start && !w_busy;
  assign w_load     = w_accept && is_muldiv(bus.md_op);
  assign w_load_val = ((bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU)) ?
                      32'(MUL_CYCLES) : 32'(DIV_CYCLES);

  mdu_latency_ctr u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .busy     (w_busy),
    .commit   (w_commit)
  );

  // Results derive only from the latched operands.
  logic        w_signed;
  logic [63:0] w_prod;
  logic [31:0] w_ua;
  logic [31:0] w_ub;
  logic [31:0] w_qmag;
  logic [31:0] w_rmag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_signed = (r_op == MD_MULT) || (r_op == MD_DIV);
  assign w_prod   = w_signed ?
                    64'($signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b})) :
                    ({32'd0, r_a} * {32'd0, r_b});

  // Signed divide through magnitudes avoids the INT_MIN / -1 overflow case.
  assign w_ua   = (w_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
  assign w_ub   = (w_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
  assign w_qmag = (w_ub == 32'd0) ? 32'd0 : (w_ua / w_ub);
  assign w_rmag = (w_ub == 32'd0) ? 32'd0 : (w_ua % w_ub);
  assign w_quot = (w_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_qmag) : w_qmag;
  assign w_rem  = (w_signed && r_a[31]) ? (32'd0 - w_rmag) : w_rmag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= MD_NONE;
      r_a  <= 32'd0;
      r_b  <= 32'd0;
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (w_load) begin
        r_op <= bus.md_op;
        r_a  <= bus.op1;
        r_b  <= bus.op2;
      end
      if (w_accept && (bus.md_op == MD_MTHI)) r_hi <= bus.op1;
      if (w_accept && (bus.md_op == MD_MTLO)) r_lo <= bus.op1;
      if (w_commit) begin
        if ((r_op == MD_MULT) || (r_op == MD_MULTU)) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end else if (r_b != 32'd0) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the ALU and takes the same forwarded rs/rt operands.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, and MTHI/MTLO in one cycle.
- Exposes HI/LO for MFHI/MFLO, plus a busy flag that the hazard unit uses to stall the pipeline.

Parameters:
- MUL_CYCLES, 5, busy duration of MULT/MULTU in cycles (legal range >=1).
- DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (legal range >=1).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- start  input  1  request strobe; qualifies md_op for one cycle.
- md_op  input  4  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-15 reserved (no-op).
- op1  input  32  rs value (dividend / multiplicand / MTHI-MTLO source).
- op2  input  32  rt value (divisor / multiplier).
- busy  output  1  a mult/div operation is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (reset=1 at an edge): hi=0, lo=0, busy=0, internal counter=0, latched operands cleared. Reset wins over any in-flight operation; no commit occurs.
- Accept condition: start=1 and busy=0 at a rising edge. If start=1 while busy=1, the request is ignored; the hazard unit guarantees this does not happen.
- Start of a mult/div (md_op 1-4) at edge T:
  - latch op1, op2 and md_op;
  - load the counter with MUL_CYCLES or DIV_CYCLES;
  - busy=1 from cycle T+1.
- Each subsequent edge decrements the counter. On the edge where counter==1:
  - HI/LO are written with the result;
  - the counter goes to 0 and busy drops.
  - Net effect: busy is high for exactly N cycles (T+1..T+N), and the new hi/lo are visible from cycle T+N+1 together with busy=0.
- MULT: 64-bit signed product of op1*op2; hi=[63:32], lo=[31:0].
- MULTU: same as MULT, unsigned.
- DIV: lo=quotient truncated toward zero; hi=remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (latched op2==0): full latency, busy behaves normally, hi/lo left unchanged at commit.
- MTHI/MTLO accepted at edge T: hi (or lo) = op1 at that same edge; busy stays 0.
- Reserved codes, and md_op=0 with start=1: no state change.
- Operands are latched at start, so op1/op2 changes during busy have no effect.
- hi/lo outputs hold their old values throughout busy; they are pure register outputs with no combinational path from inputs.
- Back-to-back operations: a new start is accepted in the first cycle busy=0, i.e. the cycle in which the committed hi/lo are first visible.
- Internal results are computed combinationally from the latched operands (64-bit product, 32-bit quotient/remainder) and written only at commit. The counter only models latency.

Decomposition:
- Shared package (mips_defs): md_op encodings MD_NONE..MD_MTLO, 4-bit width constant, default MUL_CYCLES/DIV_CYCLES.
- One natural sub-module: mdu_latency_ctr (load value, decrement, busy, commit pulse). The arithmetic stays in mdu_hilo.

Test Plan:
1. Reset: assert reset for 2 cycles mid-DIV -> hi=0, lo=0, busy=0 the cycle after; no commit afterwards.
2. MULT op1=0xFFFFFFFE (-2), op2=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. DIV op1=0xFFFFFFF9 (-7), op2=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
4. Divide by zero with hi=0x11111111, lo=0x22222222 preset via MTHI/MTLO, then DIVU 5/0 -> busy 10 cycles; hi/lo unchanged.
5. MTHI op1=0xDEADBEEF -> hi=0xDEADBEEF the next cycle, busy never asserts. Start MULT while busy from an earlier DIV -> ignored; only the DIV result commits.
6. Operand hold and back-to-back: change op1/op2 every cycle during MULT 6*7 -> lo=42. Start DIVU 100/7 on the first busy=0 cycle -> accepted; lo=14, hi=2 after 10 cycles.
